// File: rtl/shift_unit_arbiter_pkg.sv
// Shared types and constants for the shift unit arbiter: FSM states, datapath widths
// and the captured operand record.
package shift_arb_pkg;

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned SHAMT_W  = 6;
  localparam int unsigned ID_MAX_W = 3;  // enough for up to 8 requesters

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [SHAMT_W-1:0]  shift;
    logic [ID_MAX_W-1:0] id;
  } operand_t;

endpackage

// File: rtl/shift_unit_arbiter_if.sv
// Request/response bundle between the requesters/consumer (master) and the arbiter (slave).
interface shift_unit_arbiter_if
  import shift_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);

  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0][DATA_W-1:0]  req_data;
  logic [NUM_REQ-1:0][SHAMT_W-1:0] req_shift;
  logic [NUM_REQ-1:0]              req_ready;
  logic                            rsp_valid;
  logic [DATA_W-1:0]               rsp_data;
  logic [ID_W-1:0]                 rsp_id;
  logic                            rsp_ready;

  modport master (
    output req_valid, req_data, req_shift, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_data, req_shift, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/logicalShift_R.sv
// Combinational 64-bit logical right shift, zero-filled from the top.
module logicalShift_R
  import shift_arb_pkg::*;
(
  input  logic [DATA_W-1:0]  a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [DATA_W-1:0]  y
);

  assign y = a >> shamt;

endmodule

// File: rtl/shift_unit_arbiter_rr_arbiter.sv
// Round-robin picker: searches from ptr+1 upward with wrap, returns one-hot grant and index.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [ID_W-1:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    // offset NUM_REQ lands back on ptr itself, so it is considered last
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      pos = ID_W'((32'(ptr) + off) % NUM_REQ);
      if (!any && req[pos]) begin
        grant[pos] = 1'b1;
        idx        = pos;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shift_unit_arbiter.sv
// Shares one logicalShift_R between NUM_REQ requesters with round-robin grant and a
// backpressured, id-tagged response. Define SHIFT_ARB_STATS_EN for per-requester grant counters.
module shift_unit_arbiter
  import shift_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  shift_unit_arbiter_if.slave  bus
`ifdef SHIFT_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][CNT_W-1:0] grant_count
`endif
);

  state_t              state, state_nxt;
  logic [ID_W-1:0]     rr_ptr;
  operand_t            op;
  logic [DATA_W-1:0]   shifted;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [ID_W-1:0]     rsp_id_q;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_any;
  logic                offer;
  logic                accept;
  logic                unused_id_bits;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  logicalShift_R u_shift (
    .a     (op.data),
    .shamt (op.shift),
    .y     (shifted)
  );

  always_comb begin
    state_nxt = state;
    offer     = 1'b0;
    case (state)
      IDLE: begin
        offer = 1'b1;
        if (grant_any) state_nxt = SHIFT;
      end
      SHIFT: state_nxt = RESP;
      RESP: begin
        // consuming the result frees the shifter, so the next grant overlaps this cycle
        if (bus.rsp_ready) begin
          offer     = 1'b1;
          state_nxt = grant_any ? SHIFT : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept        = offer && grant_any && !reset;
  assign bus.req_ready = (offer && !reset) ? grant : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign unused_id_bits = ^op.id;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      op          <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rr_ptr   <= grant_idx;
        op.data  <= bus.req_data[grant_idx];
        op.shift <= bus.req_shift[grant_idx];
        op.id    <= ID_MAX_W'(grant_idx);
      end
      if (state == SHIFT) begin
        rsp_data_q  <= shifted;
        rsp_id_q    <= op.id[ID_W-1:0];
        rsp_valid_q <= 1'b1;
      end else if (state == RESP && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

`ifdef SHIFT_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_count <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (accept && grant[i] && grant_count[i] != '1)
          grant_count[i] <= grant_count[i] + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed bench for shift_unit_arbiter: table-driven single transactions plus round-robin,
// backpressure, mid-operation reset and (with SHIFT_ARB_STATS_EN) counter saturation sequences.
module tb_shift_unit_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned CNT_W   = 4;

  logic clk;
  logic reset;

  int checks = 0;
  int errors = 0;

  shift_unit_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

`ifdef SHIFT_ARB_STATS_EN
  logic [NUM_REQ-1:0][CNT_W-1:0] grant_count;
`endif

  shift_unit_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus)
`ifdef SHIFT_ARB_STATS_EN
    ,
    .grant_count (grant_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int unsigned idx;
    logic [63:0] data;
    logic [5:0]  shift;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // one isolated transaction from requester idx, consumer always ready
  task automatic single(input int unsigned idx, input logic [63:0] d, input logic [5:0] s,
                        input logic [63:0] exp, input string tag);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    bus.req_data[idx]  = d;
    bus.req_shift[idx] = s;
    bus.req_valid      = onehot;
    #1 chk({tag, "_ready"}, 64'(bus.req_ready), 64'(onehot));
    @(negedge clk);
    bus.req_valid = '0;
    chk({tag, "_shift_nvalid"}, 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 64'(bus.rsp_valid), 64'd1);
    chk({tag, "_data"}, bus.rsp_data, exp);
    chk({tag, "_id"}, 64'(bus.rsp_id), 64'(idx));
    @(negedge clk);
    chk({tag, "_done"}, 64'(bus.rsp_valid), 64'd0);
  endtask

  int unsigned gr_exp[5];
  int unsigned grants[$];
  int unsigned rids[$];
  logic [63:0] held_data;

  initial begin
    vecs[0] = '{1, 64'd455, 6'd6, 64'd7};
    vecs[1] = '{2, 64'd1024, 6'd10, 64'd1};
    vecs[2] = '{3, 64'd1024, 6'd11, 64'd0};
    vecs[3] = '{0, 64'h8000_0000_0000_0000, 6'd63, 64'd1};
    vecs[4] = '{1, 64'h8000_0000_0000_0000, 6'd0, 64'h8000_0000_0000_0000};
    vecs[5] = '{2, 64'hFFFF_FFFF_FFFF_FFFF, 6'd32, 64'h0000_0000_FFFF_FFFF};
    vecs[6] = '{3, 64'h0123_4567_89AB_CDEF, 6'd4, 64'h0012_3456_789A_BCDE};
    vecs[7] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 64'd1};
    gr_exp = '{1, 2, 3, 0, 1};

    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_shift = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_data", bus.rsp_data, 64'd0);
    chk("rst_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_ready", 64'(bus.req_ready), 64'd0);
      chk("idle_valid", 64'(bus.rsp_valid), 64'd0);
      chk("idle_data", bus.rsp_data, 64'd0);
    end

    @(negedge clk);
    for (int v = 0; v < 8; v++)
      single(vecs[v].idx, vecs[v].data, vecs[v].shift, vecs[v].exp, $sformatf("vec%0d", v));

    // round robin with all requesters continuously valid
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req_data[i]  = 64'd1024;
      bus.req_shift[i] = 6'(9 + i);
    end
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 30 && grants.size() < 5; c++) begin
      #1;
      for (int i = 0; i < 4; i++)
        if (bus.req_valid[i] && bus.req_ready[i]) grants.push_back(i);
      if (bus.rsp_valid) begin
        rids.push_back(bus.rsp_id);
        chk("rr_data", bus.rsp_data, 64'd1024 >> (9 + bus.rsp_id));
      end
      @(negedge clk);
    end
    bus.req_valid = '0;
    chk("rr_grant_cnt", 64'(grants.size()), 64'd5);
    for (int k = 0; k < 5; k++)
      if (k < grants.size()) chk($sformatf("rr_grant%0d", k), 64'(grants[k]), 64'(gr_exp[k]));
    for (int k = 0; k < 3; k++)
      if (k < rids.size()) chk($sformatf("rr_rid%0d", k), 64'(rids[k]), 64'(gr_exp[k]));
    repeat (4) @(negedge clk);

    // backpressure: response held, no grants, then grant in the release cycle
    do_reset();
    bus.rsp_ready    = 1'b0;
    bus.req_data[2]  = 64'hDEAD_BEEF_0000_0000;
    bus.req_shift[2] = 6'd32;
    bus.req_data[3]  = 64'h0000_0000_0000_00F0;
    bus.req_shift[3] = 6'd4;
    bus.req_valid    = 4'b0100;
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
    held_data = 64'h0000_0000_DEAD_BEEF;
    for (int c = 0; c < 10; c++) begin
      bus.req_valid = (c < 5) ? 4'b1111 : 4'b1000;
      #1;
      chk("bp_hold_valid", 64'(bus.rsp_valid), 64'd1);
      chk("bp_hold_data", bus.rsp_data, held_data);
      chk("bp_hold_id", 64'(bus.rsp_id), 64'd2);
      chk("bp_no_grant", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1 chk("bp_release_grant", 64'(bus.req_ready), 64'b1000);
    @(negedge clk);
    bus.req_valid = '0;
    chk("bp_consumed", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    chk("bp_next_valid", 64'(bus.rsp_valid), 64'd1);
    chk("bp_next_data", bus.rsp_data, 64'h0F);
    chk("bp_next_id", 64'(bus.rsp_id), 64'd3);
    @(negedge clk);

    // reset while in SHIFT
    do_reset();
    bus.req_data[1]  = 64'd455;
    bus.req_shift[1] = 6'd6;
    bus.req_valid    = 4'b0010;
    @(negedge clk);
    bus.req_valid = '0;
    reset = 1'b1;
    @(negedge clk);
    chk("rs_shift_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rs_shift_data", bus.rsp_data, 64'd0);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rs_shift_noresp", 64'(bus.rsp_valid), 64'd0);
    end

    // reset while in RESP
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0010;
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    chk("rs_resp_pre", 64'(bus.rsp_valid), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rs_resp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rs_resp_data", bus.rsp_data, 64'd0);
    chk("rs_resp_id", 64'(bus.rsp_id), 64'd0);
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);

`ifdef SHIFT_ARB_STATS_EN
    do_reset();
    chk("cnt_reset", 64'(grant_count), 64'd0);
    for (int n = 0; n < 17; n++) begin
      single(0, 64'd8, 6'd3, 64'd1, "cnt_txn");
      if (n == 13) chk("cnt_14", 64'(grant_count[0]), 64'd14);
    end
    chk("cnt_sat", 64'(grant_count[0]), 64'd15);
    chk("cnt_other", 64'(grant_count[1]), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
